fetch_queue: RTL and testbench

- Dual-issue fetch front end for the superscalar core.
- Owns the fetch PC and drives the word address of the 2-wide instruction ROM.
- Captures the ROM's registered instruction pair (1-cycle latency) into a circular queue.
- Presents up to two in-order instructions with PCs per cycle to decode, with valid/ready handshake and branch/jump redirect flush.

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, requests instruction pairs from a 2-wide ROM and queues them for dual-issue decode.
// Define FETCH_QUEUE_PERF_EN to add the perf_* counter ports.
module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 10,
  parameter int RESET_WORD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid1,
  output logic [31:0]       out_instr1,
  output logic [31:0]       out_pc1,
  output logic              out_valid2,
  output logic [31:0]       out_instr2,
  output logic [31:0]       out_pc2,
  input  logic              dec_ready1,
  input  logic              dec_ready2
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_fetch_pairs,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_redirects
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_q, req_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic             credit_ok, issue, capture, take1, take2;
  logic [1:0]       n_take;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{redirect_pc[31:ADDR_W+2], redirect_pc[1:0]};

  // Four free entries cover the pair already in flight plus the one issued now.
  assign credit_ok = count_q <= CNT_W'(DEPTH - 4);
  assign issue     = credit_ok & ~redirect_valid;
  assign capture   = req_q & ~redirect_valid;

  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);
  assign rom_addr = fetch_pc_q;

  assign out_valid1 = (count_q != '0) & ~redirect_valid;
  assign out_valid2 = (count_q > CNT_W'(1)) & ~redirect_valid;
  assign out_instr1 = out_valid1 ? instr_mem[head_q]  : NOP;
  assign out_instr2 = out_valid2 ? instr_mem[head_p1] : NOP;
  assign out_pc1    = out_valid1 ? {{(30-ADDR_W){1'b0}}, pc_mem[head_q], 2'b00}  : '0;
  assign out_pc2    = out_valid2 ? {{(30-ADDR_W){1'b0}}, pc_mem[head_p1], 2'b00} : '0;

  assign take1  = out_valid1 & dec_ready1;
  assign take2  = take1 & out_valid2 & dec_ready2;
  assign n_take = {1'b0, take1} + {1'b0, take2};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc[ADDR_W+1:2];
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        req_d      = 1'b1;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(2);
      end
      if (capture) tail_d = tail_q + PTR_W'(2);
      head_d  = head_q + PTR_W'(n_take);
      count_d = count_q + (capture ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(n_take);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= ADDR_W'(RESET_WORD);
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is visible until count covers it.
  always_ff @(posedge clk) begin
    if (capture) begin
      instr_mem[tail_q]  <= rom_instr1;
      instr_mem[tail_p1] <= rom_instr2;
      pc_mem[tail_q]     <= req_pc_q;
      pc_mem[tail_p1]    <= req_pc_q + ADDR_W'(1);
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_pairs_q, perf_stall_q, perf_redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pairs_q <= '0;
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (capture && perf_pairs_q != '1) perf_pairs_q <= perf_pairs_q + 32'd1;
      if (!redirect_valid && !credit_ok && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && perf_redir_q != '1) perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_fetch_pairs  = perf_pairs_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: a registered 2-wide ROM model holds word i = 32'h1000_0000 + i.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_queue;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int NWORDS = 1 << ADDR_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [ADDR_W-1:0] rom_addr, rom_addr_p1;
  logic [31:0] rom_instr1 = '0, rom_instr2 = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid1, out_valid2;
  logic [31:0] out_instr1, out_instr2, out_pc1, out_pc2;
  logic dec_ready1 = 1'b1, dec_ready2 = 1'b1;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetch_pairs, perf_stall_cycles, perf_redirects;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_word = 0;

  always #5 clk = ~clk;

  assign rom_addr_p1 = rom_addr + ADDR_W'(1);
  always @(posedge clk) begin
    rom_instr1 <= 32'h1000_0000 + 32'(rom_addr);
    rom_instr2 <= 32'h1000_0000 + 32'(rom_addr_p1);
  end

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_WORD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr),
    .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1),
    .out_valid2(out_valid2), .out_instr2(out_instr2), .out_pc2(out_pc2),
    .dec_ready1(dec_ready1), .dec_ready2(dec_ready2)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetch_pairs(perf_fetch_pairs), .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects)
`endif
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b expected 0", out_valid1); end
    n_vec++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL reset_valid2: got %b expected 0", out_valid2); end
    n_vec++; if (out_instr1 !== NOP) begin n_err++; $display("FAIL reset_instr1: got %h expected %h", out_instr1, NOP); end
    n_vec++; if (out_instr2 !== NOP) begin n_err++; $display("FAIL reset_instr2: got %h expected %h", out_instr2, NOP); end
    n_vec++; if (out_pc1 !== 32'h0 || out_pc2 !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h/%h expected 0/0", out_pc1, out_pc2); end
    n_vec++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    rst_n = 1'b1;
    exp_word = 0;
  endtask

  // First pair visible two cycles after release, then one pair per cycle with no bubble.
  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dec_ready1 = 1'b1; dec_ready2 = 1'b1;
      #1;
      n_vec++; if (rom_addr !== 10'(2 * (k + 1))) begin n_err++; $display("FAIL stream_rom_addr[%0d]: got %0d expected %0d", k, rom_addr, 2 * (k + 1)); end
      if (k == 0) begin
        n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL stream_early_valid: got %b expected 0", out_valid1); end
      end else begin
        n_vec++;
        if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1 || out_pc1 !== 32'(8 * (k - 1)) || out_pc2 !== 32'(8 * (k - 1) + 4) ||
            out_instr1 !== 32'h1000_0000 + 32'(2 * (k - 1)) || out_instr2 !== 32'h1000_0001 + 32'(2 * (k - 1))) begin
          n_err++;
          $display("FAIL stream_pair[%0d]: got v=%b%b pc=%h/%h instr=%h/%h expected v=11 pc=%h/%h", k, out_valid1, out_valid2,
                   out_pc1, out_pc2, out_instr1, out_instr2, 32'(8 * (k - 1)), 32'(8 * (k - 1) + 4));
        end
        exp_word = exp_word + 2;
      end
    end
  endtask

  // Decode blocked: queue fills to DEPTH and fetch freezes DEPTH words past the head.
  task automatic test_stall();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      dec_ready1 = 1'b0; dec_ready2 = 1'b1;
      #1;
      n_vec++;
      if (out_valid1 !== 1'b1 || out_pc1 !== 32'(exp_word * 4)) begin
        n_err++; $display("FAIL stall_head[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid1, out_pc1, 32'(exp_word * 4));
      end
      if (k >= 5) begin
        n_vec++;
        if (rom_addr !== 10'(exp_word + DEPTH)) begin
          n_err++; $display("FAIL stall_rom_frozen[%0d]: got %0d expected %0d", k, rom_addr, exp_word + DEPTH);
        end
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    int w1, w2;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dec_ready1 = 1'b1; dec_ready2 = 1'b1;
      #1;
      w1 = exp_word % NWORDS;
      w2 = (exp_word + 1) % NWORDS;
      if (out_valid1 === 1'b1) begin
        n_vec++;
        if (out_pc1 !== 32'(w1 * 4) || out_instr1 !== 32'h1000_0000 + 32'(w1)) begin
          n_err++; $display("FAIL b2b_slot1: got pc=%h instr=%h expected pc=%h instr=%h", out_pc1, out_instr1, 32'(w1 * 4), 32'h1000_0000 + 32'(w1));
        end
        if (out_valid2 === 1'b1) begin
          n_vec++;
          if (out_pc2 !== 32'(w2 * 4) || out_instr2 !== 32'h1000_0000 + 32'(w2)) begin
            n_err++; $display("FAIL b2b_slot2: got pc=%h instr=%h expected pc=%h instr=%h", out_pc2, out_instr2, 32'(w2 * 4), 32'h1000_0000 + 32'(w2));
          end
          exp_word = (exp_word + 2) % NWORDS;
        end else begin
          exp_word = (exp_word + 1) % NWORDS;
        end
      end
    end
  endtask

  task automatic test_single_issue();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dec_ready1 = 1'b1; dec_ready2 = 1'b0;
      #1;
      n_vec++;
      if (out_valid1 !== 1'b1 || out_pc1 !== 32'((exp_word % NWORDS) * 4)) begin
        n_err++; $display("FAIL single_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid1, out_pc1, 32'((exp_word % NWORDS) * 4));
      end
      exp_word = (exp_word + 1) % NWORDS;
    end
  endtask

  task automatic test_redirect_wrap();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFC;
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || out_instr1 !== NOP) begin
      n_err++; $display("FAIL redir_forced_invalid: got v=%b%b instr=%h expected v=00 instr=%h", out_valid1, out_valid2, out_instr1, NOP);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || rom_addr !== 10'd1023) begin
      n_err++; $display("FAIL redir_cycle1: got v=%b rom_addr=%0d expected v=0 rom_addr=1023", out_valid1, rom_addr);
    end
    @(negedge clk);
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || rom_addr !== 10'd1) begin
      n_err++; $display("FAIL redir_cycle2: got v=%b rom_addr=%0d expected v=0 rom_addr=1", out_valid1, rom_addr);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1 || out_pc1 !== 32'h0000_0FFC || out_pc2 !== 32'h0 ||
        out_instr1 !== 32'h1000_03FF || out_instr2 !== 32'h1000_0000) begin
      n_err++; $display("FAIL redir_wrap_pair: got v=%b%b pc=%h/%h instr=%h/%h expected v=11 pc=00000ffc/00000000 instr=100003ff/10000000",
                        out_valid1, out_valid2, out_pc1, out_pc2, out_instr1, out_instr2);
    end
    exp_word = 1;
  endtask

  // Redirect while a pair is presented, decode is ready and a capture is due at the same edge.
  task automatic test_redirect_collide();
    @(negedge clk);
    dec_ready1 = 1'b1; dec_ready2 = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0105;
    #1;
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL collide_forced: got %b expected 0", out_valid1); end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL collide_empty[%0d]: got %b expected 0", k, out_valid1); end
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid1 !== 1'b1 || out_pc1 !== 32'h0000_0104 || out_pc2 !== 32'h0000_0108 || out_instr1 !== 32'h1000_0041) begin
      n_err++; $display("FAIL collide_restart: got v=%b pc=%h/%h instr=%h expected v=1 pc=00000104/00000108 instr=10000041",
                        out_valid1, out_pc1, out_pc2, out_instr1);
    end
    exp_word = 32'h43;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dec_ready1 = 1'b0;
    end
`ifdef FETCH_QUEUE_PERF_EN
    #1;
    n_vec++; if (perf_redirects !== 32'd2) begin n_err++; $display("FAIL perf_redirects: got %0d expected 2", perf_redirects); end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || out_instr1 !== NOP || out_instr2 !== NOP) begin
      n_err++; $display("FAIL midrst_outputs: got v=%b%b instr=%h/%h expected v=00 instr=%h/%h", out_valid1, out_valid2, out_instr1, out_instr2, NOP, NOP);
    end
    n_vec++; if (out_pc1 !== 32'h0 || out_pc2 !== 32'h0 || rom_addr !== 10'd0) begin
      n_err++; $display("FAIL midrst_pc: got pc=%h/%h rom_addr=%0d expected 0/0/0", out_pc1, out_pc2, rom_addr);
    end
`ifdef FETCH_QUEUE_PERF_EN
    n_vec++; if (perf_fetch_pairs !== 32'd0 || perf_stall_cycles !== 32'd0 || perf_redirects !== 32'd0) begin
      n_err++; $display("FAIL midrst_perf: got %0d/%0d/%0d expected 0/0/0", perf_fetch_pairs, perf_stall_cycles, perf_redirects);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1; dec_ready1 = 1'b1; dec_ready2 = 1'b1;
    @(negedge clk);
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || rom_addr !== 10'd2) begin
      n_err++; $display("FAIL midrst_restart1: got v=%b rom_addr=%0d expected v=0 rom_addr=2", out_valid1, rom_addr);
    end
    @(negedge clk);
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h0 || out_pc2 !== 32'h4 || out_instr1 !== 32'h1000_0000) begin
      n_err++; $display("FAIL midrst_restart2: got v=%b pc=%h/%h instr=%h expected v=1 pc=0/4 instr=10000000", out_valid1, out_pc1, out_pc2, out_instr1);
    end
    exp_word = 2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back(12);
    test_single_issue();
    test_back_to_back(6);
    test_redirect_wrap();
    test_back_to_back(8);
    test_redirect_collide();
    test_back_to_back(6);
    test_mid_reset();
    test_back_to_back(6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
